instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the stack processor: the consumer of the PC register's `newPC`. It reads the instruction at the current PC from instruction memory over a req/ack handshake and presents it to decode over a valid/ready handshake. It drives the PC register's `regWrite` with a one-cycle pulse per accepted fetch, so the PC advances by 2. It also discards in-flight or held instructions on a branch flush.

## Interface
- `ADDR_W`, 16, PC / memory address width (byte address; PC steps by 2)
- `INSTR_W`, 16, instruction width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `pc`  in  ADDR_W  current PC, from PC register `newPC`
- `pc_write`  out  1  to PC register `regWrite`; one-cycle advance pulse
- `flush`  in  1  branch/jump taken; PC is being reloaded this cycle
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_W  read address
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  INSTR_W  read data
- `ir`  out  INSTR_W  held instruction
- `ir_pc`  out  ADDR_W  address `ir` was fetched from
- `ir_valid`  out  1  `ir` valid for decode
- `ir_ready`  in  1  decode accepts `ir`
- `fetch_count`  out  16  instructions accepted by decode, wraps 0xFFFF→0

## Operation
- States: IDLE, REQ, DROP, HOLD.
- Reset (`reset`=0 at an edge):
  - state=IDLE.
  - `ir`, `ir_pc`, `fetch_count` = 0.
  - `ir_valid`, `pc_write`, `mem_req` = 0.
  - `mem_addr` = `pc`.
- IDLE → REQ unconditionally on the first edge with `reset`=1.
- REQ:
  - `mem_req`=1; `mem_addr`=`pc` (combinational; `pc` is stable because `pc_write`=0 throughout REQ).
  - On `mem_ack`, no `flush`: `ir`←`mem_rdata`, `ir_pc`←`pc`, `ir_valid`←1, `pc_write` pulses for the next cycle, → HOLD.
  - On `flush`, no `mem_ack`: → DROP. A request is never aborted; `mem_req` stays 1.
  - On `flush` and `mem_ack` together: data discarded, no `pc_write`, stay REQ. The next cycle requests the new `pc`.
- DROP:
  - `mem_req`=1, `mem_addr`=`pc`.
  - On `mem_ack`: data discarded, no `pc_write`, → REQ.
  - `flush` in DROP has no additional effect.
- HOLD:
  - `ir_valid`=1; `ir` and `ir_pc` are stable.
  - On `ir_ready`, no `flush`: `ir_valid`←0, `fetch_count`+1, → REQ.
  - On `flush` (with or without `ir_ready`): `ir_valid`←0, `fetch_count` unchanged, → REQ. Flush wins.
- `pc_write`:
  - Registered pulse, gated combinationally: `pc_write` = `pc_write_q` & ~`flush`. A branch reload therefore never coincides with an increment.
  - Exactly one pulse per instruction captured; never more than one cycle wide.
- `mem_addr` is don't-care when `mem_req`=0. Outputs are otherwise registered.
- `fetch_count` increments only on a non-flushed `ir_valid`&`ir_ready` edge.

## Timing
- Memory ack sampled at edge k:
  - `ir_valid`=1 and `pc_write`=1 during cycle k..k+1.
  - PC register increments at edge k+1.
- Earliest new request is the cycle after edge k+1 (`ir_ready` held high). `mem_addr` then equals old `pc`+2.
- Throughput with zero-wait memory (ack in the first REQ cycle) and `ir_ready`=1: one instruction per 2 cycles.
- Reset mid-operation:
  - Takes effect at that edge regardless of state.
  - A pending `mem_ack` in the reset cycle is ignored.
  - The memory must tolerate a dropped request.
- `flush` is a single-cycle pulse. The new PC is visible on `pc` in the cycle after `flush`.

## Test plan
- **Reset/idle:** hold `reset`=0 for 5 cycles with `mem_ack`=1, `pc`=0x0010.
  - During reset: all outputs 0, `mem_req`=0.
  - First cycle after release: IDLE.
  - Second cycle: `mem_req`=1, `mem_addr`=0x0010.
- **Streaming:** PC register from 0, zero-wait memory returning `mem_rdata`=addr^0xA5A5, `ir_ready`=1, 4 fetches.
  - `ir` = 0xA5A5, 0xA5A7, 0xA5A1, 0xA5A3.
  - `ir_pc` = 0, 2, 4, 6.
  - `pc_write` pulses 4 times, each 1 cycle; `fetch_count`=4.
- **Backpressure:** `ir_ready`=0 for 6 cycles after capture.
  - `ir_valid` stays 1; `ir` stable; `mem_req`=0.
  - `pc` advances exactly once (by 2).
  - On `ir_ready`=1: `fetch_count`+1 and a new request at `pc`+2.
- **Flush in REQ, ack 3 cycles later:** `pc` reloaded to 0x0100 by the branch source.
  - Old data dropped; no `pc_write`; `ir_valid` stays 0.
  - Next request has `mem_addr`=0x0100.
- **Flush in HOLD with simultaneous `ir_ready`:**
  - `ir_valid`→0; `fetch_count` unchanged.
  - `pc_write` is 0 in the flush cycle even if `pc_write_q`=1.
- **Wrap and reset mid-fetch:**
  - With `fetch_count` preset via 65535 accepts, the next accept gives 0x0000.
  - `reset`=0 asserted in DROP returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the decode-facing
// instruction register handshake. master = fetch unit, slave = memory/decode side.
interface instr_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        output mem_req, mem_addr, ir, ir_pc, ir_valid,
        input  mem_ack, mem_rdata, ir_ready
    );

    modport slave (
        input  mem_req, mem_addr, ir, ir_pc, ir_valid,
        output mem_ack, mem_rdata, ir_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the instruction at pc over req/ack, holds it
// for decode over valid/ready, and pulses pc_write once per captured instruction.
module instr_fetch #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_write,
    input  logic              flush,
    instr_fetch_if.master     bus,
    output logic [15:0]       fetch_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               pc_write_q, pc_write_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            pc_write_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            pc_write_q    <= pc_write_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        pc_write_d    = 1'b0;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A flush coinciding with ack discards the data and re-requests
                // at the reloaded pc next cycle; a flush alone must wait out the ack.
                if (bus.mem_ack && !flush) begin
                    ir_d       = bus.mem_rdata;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_write_d = 1'b1;
                    state_d    = HOLD;
                end else if (flush && !bus.mem_ack) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.mem_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (bus.ir_ready) begin
                    ir_valid_d    = 1'b0;
                    fetch_count_d = fetch_count_q + 16'd1;
                    state_d       = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with flush keeps a branch reload from colliding with an increment.
    assign pc_write     = pc_write_q & ~flush;
    assign bus.mem_req  = (state_q == REQ) || (state_q == DROP);
    assign bus.mem_addr = pc;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign fetch_count  = fetch_count_q;
endmodule
